// File: rtl/io_ccff_loader.sv
// io_ccff_loader: feeds bitstream words serially into a tile's configuration
// chain. It can also recirculate the chain through itself to check a
// ones-count signature without disturbing the chain contents.
module io_ccff_loader #(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              readback_req,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              loaded
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(CHAIN_LEN);
  // A word can never carry more useful bits than the whole chain holds.
  localparam logic [CW-1:0] WW_C  = CW'((WORD_W > CHAIN_LEN) ? CHAIN_LEN : WORD_W);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_READBACK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     wbits_q, wbits_d;   // bits left in the current word
  logic [CW-1:0]     rem_q, rem_d;       // bits left in the whole load
  logic [CW-1:0]     sig_q, sig_d;       // ones shifted in during the last load
  logic [CW-1:0]     rbcnt_q, rbcnt_d;   // ones seen at the tail during readback
  logic [CW-1:0]     bitcnt_q, bitcnt_d; // readback cycles remaining
  logic              err_q, err_d;
  logic              loaded_q, loaded_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      wbits_q  <= '0;
      rem_q    <= '0;
      sig_q    <= '0;
      rbcnt_q  <= '0;
      bitcnt_q <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      wbits_q  <= wbits_d;
      rem_q    <= rem_d;
      sig_q    <= sig_d;
      rbcnt_q  <= rbcnt_d;
      bitcnt_q <= bitcnt_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  // Next-state logic for the load / readback sequencer.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    wbits_d  = wbits_q;
    rem_d    = rem_q;
    sig_d    = sig_q;
    rbcnt_d  = rbcnt_q;
    bitcnt_d = bitcnt_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          sig_d   = '0;
          rem_d   = LEN_C;
          state_d = S_FETCH;
        end else if (readback_req) begin
          if (loaded_q) begin
            err_d    = 1'b0;
            bitcnt_d = LEN_C;
            rbcnt_d  = '0;
            state_d  = S_READBACK;
          end else begin
            // Nothing to compare against: flag it immediately.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (cfg_valid) begin
          shreg_d = cfg_data;
          wbits_d = (rem_q < WW_C) ? rem_q : WW_C;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d = shreg_q >> 1;
        wbits_d = wbits_q - ONE_C;
        rem_d   = rem_q - ONE_C;
        sig_d   = sig_q + CW'(shreg_q[0]);
        if (wbits_q == ONE_C) begin
          if (rem_q == ONE_C) begin
            loaded_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_READBACK: begin
        rbcnt_d  = rbcnt_q + CW'(ccff_tail);
        bitcnt_d = bitcnt_q - ONE_C;
        if (bitcnt_q == ONE_C) begin
          err_d   = (rbcnt_d != sig_q);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_ready = (state_q == S_FETCH);
  assign chain_en  = (state_q == S_SHIFT) || (state_q == S_READBACK);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign error     = err_q;
  assign loaded    = loaded_q;
  // Readback closes the ring combinationally so it stays CHAIN_LEN long.
  assign ccff_head = (state_q == S_READBACK) ? ccff_tail
                                             : ((state_q == S_SHIFT) & shreg_q[0]);

endmodule

// File: tb/tb_io_ccff_loader.sv
// Bench for io_ccff_loader: two instances (8/8 and 12/8), each driving a
// behavioural model of its configuration chain.
module tb_io_ccff_loader;

  logic prog_clk, prog_reset;
  logic sel, start_x, rb_x, valid_x, corrupt_x;
  logic [7:0] data_x;

  // Instance A: CHAIN_LEN=8, WORD_W=8
  logic rdy_a, head_a, en_a, busy_a, done_a, err_a, ld_a;
  logic [7:0] chain_a;
  // Instance B: CHAIN_LEN=12, WORD_W=8
  logic rdy_b, head_b, en_b, busy_b, done_b, err_b, ld_b;
  logic [11:0] chain_b;

  io_ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_a (
    .prog_clk(prog_clk), .prog_reset(prog_reset),
    .start(start_x & ~sel), .readback_req(rb_x & ~sel),
    .cfg_data(data_x), .cfg_valid(valid_x & ~sel), .cfg_ready(rdy_a),
    .ccff_head(head_a), .chain_en(en_a), .ccff_tail(chain_a[7]),
    .busy(busy_a), .done(done_a), .error(err_a), .loaded(ld_a));

  io_ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_b (
    .prog_clk(prog_clk), .prog_reset(prog_reset),
    .start(start_x & sel), .readback_req(rb_x & sel),
    .cfg_data(data_x), .cfg_valid(valid_x & sel), .cfg_ready(rdy_b),
    .ccff_head(head_b), .chain_en(en_b), .ccff_tail(chain_b[11]),
    .busy(busy_b), .done(done_b), .error(err_b), .loaded(ld_b));

  // Chain models: index 0 is the head stage, top index is the tail.
  always @(posedge prog_clk) begin
    if (en_a) chain_a <= {chain_a[6:0], head_a};
    else if (corrupt_x) chain_a[3] <= ~chain_a[3];
    if (en_b) chain_b <= {chain_b[10:0], head_b};
  end

  logic o_rdy, o_head, o_en, o_busy, o_done, o_err, o_ld;
  assign o_rdy  = sel ? rdy_b  : rdy_a;
  assign o_head = sel ? head_b : head_a;
  assign o_en   = sel ? en_b   : en_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_err  = sel ? err_b  : err_a;
  assign o_ld   = sel ? ld_b   : ld_a;

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  int n_chk = 0;
  int n_fail = 0;
  logic exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rdy"},  o_rdy,  0);
    chk({tag, "_en"},   o_en,   0);
    chk({tag, "_head"}, o_head, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"},  o_err,  0);
    chk({tag, "_ld"},   o_ld,   0);
  endtask

  // Load words into the selected instance. Cycle 0 is the negedge where start is
  // driven; the expected head bit stream is queued up front and popped while
  // chain_en is high. The first FETCH is stalled for 'stall' cycles.
  task automatic do_load(input logic s, input logic [7:0] w0, input logic [7:0] w1,
                         input int nwords, input int len, input int stall, input int exp_done);
    logic [7:0] w[2];
    int rem, nb, widx, fcnt, en_cnt, hs;
    logic got;
    w[0] = w0; w[1] = w1;
    rem = len;
    for (int k = 0; k < nwords; k++) begin
      nb = (rem < 8) ? rem : 8;
      for (int j = 0; j < nb; j++) exp_q.push_back(w[k][j]);
      rem -= nb;
    end
    @(negedge prog_clk);
    sel = s; start_x = 1'b1; valid_x = 1'b0; data_x = w[0];
    widx = 0; fcnt = 0; en_cnt = 0; hs = 0; got = 1'b0;
    for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
      @(negedge prog_clk);
      start_x = 1'b0;
      if (cyc == 1) chk("err_clr_after_start", o_err, 0);
      if (o_en) begin
        en_cnt++;
        if (exp_q.size() > 0) chk("head_bit", o_head, exp_q.pop_front());
      end
      if (o_rdy) begin
        chk("en_in_fetch", o_en, 0);
        if (fcnt < stall) begin
          valid_x = 1'b0;
          fcnt++;
        end else begin
          valid_x = 1'b1;
          data_x = w[widx];
          widx++;
          hs++;
        end
      end else begin
        valid_x = 1'b0;
      end
      if (o_done) begin
        got = 1'b1;
        chk("load_done_cycle", cyc, exp_done);
        chk("loaded", o_ld, 1);
      end
    end
    valid_x = 1'b0;
    chk("load_done_seen", got, 1);
    chk("load_en_cycles", en_cnt, len);
    chk("handshakes", hs, nwords);
    chk("bits_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_rb(input logic s, input logic exp_err, input int exp_done, input int exp_en);
    int en_cnt;
    logic got;
    @(negedge prog_clk);
    sel = s; rb_x = 1'b1; en_cnt = 0; got = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge prog_clk);
      rb_x = 1'b0;
      if (o_en) en_cnt++;
      if (o_done) begin
        got = 1'b1;
        chk("rb_done_cycle", cyc, exp_done);
        chk("rb_error", o_err, exp_err);
      end
    end
    chk("rb_done_seen", got, 1);
    chk("rb_en_cycles", en_cnt, exp_en);
  endtask

  initial begin
    logic [7:0] ea, saved;
    logic [11:0] eb;
    logic [11:0] stream;
    sel = 1'b0; start_x = 1'b0; rb_x = 1'b0; valid_x = 1'b0; data_x = '0;
    corrupt_x = 1'b0; prog_reset = 1'b1;
    repeat (3) @(negedge prog_clk);
    prog_reset = 1'b0;
    @(negedge prog_clk);
    sel = 1'b0; chk_idle_zero("rstA");
    sel = 1'b1; chk_idle_zero("rstB");

    // Full-word load into the 8-stage chain.
    do_load(1'b0, 8'hA5, 8'h00, 1, 8, 0, 10);
    for (int i = 0; i < 8; i++) ea[7-i] = 8'hA5 >> i;
    chk("chainA_after_load", chain_a, ea);

    // Readback leaves the chain intact and matches.
    saved = chain_a;
    do_rb(1'b0, 1'b0, 9, 8);
    chk("chainA_after_rb", chain_a, saved);

    // Corrupt one stage; readback flags it and the flag sticks.
    @(negedge prog_clk); corrupt_x = 1'b1;
    @(negedge prog_clk); corrupt_x = 1'b0;
    do_rb(1'b0, 1'b1, 9, 8);
    repeat (2) @(negedge prog_clk);
    chk("error_sticky", o_err, 1);

    // Reload with a 5-cycle source stall; start clears the error.
    do_load(1'b0, 8'hA5, 8'h00, 1, 8, 5, 15);
    chk("chainA_after_stall", chain_a, ea);

    // Partial final word on the 12-stage chain.
    do_load(1'b1, 8'hFF, 8'h3C, 2, 12, 0, 15);
    stream = {4'b1100, 8'hFF};
    for (int i = 0; i < 12; i++) eb[11-i] = stream[i];
    chk("chainB_after_load", chain_b, eb);

    // Reset in the middle of a load.
    @(negedge prog_clk);
    sel = 1'b0; start_x = 1'b1; valid_x = 1'b1; data_x = 8'h5A;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge prog_clk);
      start_x = 1'b0;
    end
    prog_reset = 1'b1;
    @(negedge prog_clk);
    prog_reset = 1'b0; valid_x = 1'b0;
    chk_idle_zero("midrst");

    // Readback with nothing loaded.
    do_rb(1'b0, 1'b1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
